// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the operand stage and the ALU.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH    = 5;
  localparam int unsigned CONTROL_WIDTH = 3;
  localparam int unsigned NUM_REGS      = 2 ** ADDR_WIDTH;

  typedef enum logic [CONTROL_WIDTH-1:0] {
    ADD = CONTROL_WIDTH'(0),
    SUB = CONTROL_WIDTH'(1)
  } alumode_t;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] REG_A0   = ADDR_WIDTH'(10);

endpackage

// File: rtl/operand_stage_if.sv
// Decode-side handshake, writeback port and ALU-side outputs of the operand stage.
interface operand_stage_if;
  import cpu_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_WIDTH-1:0]    rs1;
  logic [ADDR_WIDTH-1:0]    rs2;
  logic [DATA_WIDTH-1:0]    imm;
  logic                     use_imm;
  logic [CONTROL_WIDTH-1:0] ctrl_in;
  logic                     flush;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [DATA_WIDTH-1:0]    op [2];
  logic [CONTROL_WIDTH-1:0] ctrl;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    dbg_a0;

  modport slave (
    input  in_valid, rs1, rs2, imm, use_imm, ctrl_in, flush,
    input  wr_en, wr_addr, wr_data, out_ready,
    output in_ready, op, ctrl, out_valid, dbg_a0
  );

  modport master (
    output in_valid, rs1, rs2, imm, use_imm, ctrl_in, flush,
    output wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, op, ctrl, out_valid, dbg_a0
  );

endinterface

// File: rtl/operand_stage_regfile.sv
// Architectural register file: x0 reads zero, two async read ports, one write port.
// OPERAND_STAGE_BYPASS_EN forwards a same-cycle write to the read ports.
module operand_stage_regfile
  import cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] ra1_i,
  input  logic [ADDR_WIDTH-1:0] ra2_i,
  input  logic                  use_imm_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic [DATA_WIDTH-1:0] rd1_o,
  output logic [DATA_WIDTH-1:0] rd2_o,
  output logic [DATA_WIDTH-1:0] dbg_a0_o
);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic                  wr_live;

  assign wr_live = we_i && (wa_i != REG_ZERO);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wr_live) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = (ra1_i == REG_ZERO) ? '0 : rf_q[ra1_i];
    rd2_o = (ra2_i == REG_ZERO) ? '0 : rf_q[ra2_i];
`ifdef OPERAND_STAGE_BYPASS_EN
    if (wr_live && (wa_i == ra1_i)) rd1_o = wd_i;
    if (wr_live && (wa_i == ra2_i)) rd2_o = wd_i;
`endif
    if (use_imm_i) rd2_o = imm_i;
  end

  assign dbg_a0_o = rf_q[REG_A0];

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute stage: register file read, operand select and a single
// valid/ready pipeline register feeding the ALU. Option: OPERAND_STAGE_BYPASS_EN.
module operand_stage
  import cpu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  operand_stage_if.slave bus
);

  logic [DATA_WIDTH-1:0]    rd1, rd2;
  logic [DATA_WIDTH-1:0]    op_q [2];
  logic [DATA_WIDTH-1:0]    op_d [2];
  logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                     valid_q, valid_d;
  logic                     in_ready, accept, consume;

  operand_stage_regfile u_regfile (
    .clk_i    (clk),
    .rst_i    (rst),
    .ra1_i    (bus.rs1),
    .ra2_i    (bus.rs2),
    .use_imm_i(bus.use_imm),
    .imm_i    (bus.imm),
    .we_i     (bus.wr_en),
    .wa_i     (bus.wr_addr),
    .wd_i     (bus.wr_data),
    .rd1_o    (rd1),
    .rd2_o    (rd2),
    .dbg_a0_o (bus.dbg_a0)
  );

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign consume  = valid_q && bus.out_ready;

  // Flush beats accept and consume; operands only move on an accept.
  always_comb begin
    op_d    = op_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      op_d[0] = rd1;
      op_d[1] = rd2;
      ctrl_d  = bus.ctrl_in;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q[0] <= '0;
      op_q[1] <= '0;
      ctrl_q  <= ADD;
      valid_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.op        = op_q;
  assign bus.ctrl      = ctrl_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage against a queue-based reference model.
module tb_operand_stage;
  import cpu_pkg::*;

`ifdef OPERAND_STAGE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_stage_if bus ();

  operand_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } entry_t;

  entry_t      q[$];     // instructions held by the stage (0 or 1)
  entry_t      shown;    // last loaded operands, visible on op/ctrl
  logic [31:0] mem [32];

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (Bypass && bus.wr_en && bus.wr_addr == r) return bus.wr_data;
    return mem[r];
  endfunction

  function automatic logic [100:0] exp_vec();
    return {q.size() != 0, (q.size() == 0) || bus.out_ready, shown.c, shown.a, shown.b, mem[10]};
  endfunction

  function automatic logic [100:0] dut_vec();
    return {bus.out_valid, bus.in_ready, bus.ctrl, bus.op[0], bus.op[1], bus.dbg_a0};
  endfunction

  task automatic model_reset();
    q.delete();
    shown = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.use_imm = 0;
    bus.ctrl_in = 0; bus.flush = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.out_ready = 1;
  endtask

  // One clock: model reacts to the inputs present before the edge.
  task automatic tick();
    bit          rdy, acc, cons, fl, we;
    entry_t      e;
    logic [4:0]  wa;
    logic [31:0] wd;
    rdy  = (q.size() == 0) || bus.out_ready;
    acc  = bus.in_valid && rdy && !bus.flush;
    cons = (q.size() != 0) && bus.out_ready;
    fl   = bus.flush;
    e.a  = model_read(bus.rs1);
    e.b  = bus.use_imm ? bus.imm : model_read(bus.rs2);
    e.c  = bus.ctrl_in;
    we = bus.wr_en; wa = bus.wr_addr; wd = bus.wr_data;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        shown = e;
      end
    end
    if (we && wa != 5'd0) mem[wa] = wd;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic send(input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                      input logic [31:0] im, input logic [2:0] c);
    bus.in_valid = 1; bus.rs1 = r1; bus.rs2 = r2; bus.use_imm = ui; bus.imm = im;
    bus.ctrl_in = c;
    tick();
    bus.in_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), exp_vec());
    end
    rst = 0;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b want=10", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    wr(1, 32'd5);
    wr(2, 32'd7);
    bus.out_ready = 0;
    send(1, 2, 0, 0, ADD);
    total++;
    if (bus.op[0] !== 32'd5 || bus.op[1] !== 32'd7 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_setup got=%h,%h,%b want=5,7,1", bus.op[0], bus.op[1], bus.out_valid);
    end
    #2 rst = 1;
    #1;
    total++;
    if (bus.op[0] !== 0 || bus.op[1] !== 0 || bus.ctrl !== 0 || bus.out_valid !== 0) begin
      bad++; $display("FAIL midrst_async got=%h,%h,%h,%b want=0,0,0,0",
                      bus.op[0], bus.op[1], bus.ctrl, bus.out_valid);
    end
    model_reset();
    rst = 0;
    bus.out_ready = 1;
    send(3, 3, 0, 0, ADD);
    total++;
    if (bus.op[0] !== 0 || bus.op[1] !== 0 || bus.out_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL midrst_accept got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_write_read();
    wr(3, 32'h0000_0010);
    wr(4, 32'hFFFF_FFFF);
    send(3, 4, 0, 0, SUB);
    total++;
    if (bus.op[0] !== 32'h10 || bus.op[1] !== 32'hFFFF_FFFF || bus.ctrl !== 3'd1 ||
        bus.out_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL write_read got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_x0_imm();
    wr(0, 32'h1234);
    send(0, 4, 1, 32'hFFFF_FFF8, ADD);
    total++;
    if (bus.op[0] !== 32'd0 || bus.op[1] !== 32'hFFFF_FFF8 || bus.ctrl !== 3'd0) begin
      bad++; $display("FAIL x0_imm got=%h,%h want=0,fffffff8", bus.op[0], bus.op[1]);
    end
    send(3, 0, 0, 0, 3'd6);
    total++;
    if (bus.op[0] !== 32'h10 || bus.op[1] !== 32'd0 || bus.ctrl !== 3'd6) begin
      bad++; $display("FAIL x0_rs2 got=%h,%h,%h want=10,0,6", bus.op[0], bus.op[1], bus.ctrl);
    end
  endtask

  task automatic test_backpressure();
    wr(6, 32'd66);
    wr(7, 32'd77);
    send(6, 7, 0, 0, ADD);
    bus.out_ready = 0;
    bus.in_valid = 1; bus.rs1 = 3; bus.rs2 = 4; bus.use_imm = 0; bus.ctrl_in = SUB;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, bus.in_ready);
      end
      tick();
      total++;
      if (bus.op[0] !== 32'd66 || bus.op[1] !== 32'd77 || bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h,%h,%b want=42,4d,1",
                        i, bus.op[0], bus.op[1], bus.out_valid);
      end
    end
    bus.out_ready = 1;
    tick();
    bus.in_valid = 0;
    total++;
    if (bus.op[0] !== 32'h10 || bus.op[1] !== 32'hFFFF_FFFF || bus.ctrl !== 3'd1 ||
        bus.out_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL stall_release got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_flush();
    bus.in_valid = 1; bus.rs1 = 6; bus.rs2 = 7; bus.use_imm = 0; bus.ctrl_in = ADD;
    bus.out_ready = 1; bus.flush = 1;
    bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h99;
    tick();
    bus.in_valid = 0; bus.flush = 0; bus.wr_en = 0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.op[0] !== 32'h10 || bus.op[1] !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL flush got=%b,%h,%h want=0,10,ffffffff", bus.out_valid, bus.op[0], bus.op[1]);
    end
    send(9, 0, 0, 0, ADD);
    total++;
    if (bus.op[0] !== 32'h99) begin
      bad++; $display("FAIL flush_write got=%h want=99", bus.op[0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    wr(5, 32'h1111_1111);
    bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'hA5A5_A5A5;
    send(5, 0, 1, 32'd3, ADD);
    bus.wr_en = 0;
    want = Bypass ? 32'hA5A5_A5A5 : 32'h1111_1111;
    total++;
    if (bus.op[0] !== want || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL bypass_rs1 got=%h want=%h", bus.op[0], want);
    end
    bus.wr_en = 1; bus.wr_addr = 8; bus.wr_data = 32'hCAFE_0001;
    send(0, 8, 0, 0, ADD);
    bus.wr_en = 0;
    want = Bypass ? 32'hCAFE_0001 : 32'd0;
    total++;
    if (bus.op[1] !== want) begin
      bad++; $display("FAIL bypass_rs2 got=%h want=%h", bus.op[1], want);
    end
    bus.wr_en = 1; bus.wr_addr = 10; bus.wr_data = 32'd42;
    #1;
    total++;
    if (bus.dbg_a0 !== 32'd0) begin
      bad++; $display("FAIL dbg_a0_early got=%h want=0", bus.dbg_a0);
    end
    tick();
    bus.wr_en = 0;
    total++;
    if (bus.dbg_a0 !== 32'd42) begin
      bad++; $display("FAIL dbg_a0 got=%h want=2a", bus.dbg_a0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.rs1       = 5'($urandom_range(0, 11));
      bus.rs2       = 5'($urandom_range(0, 11));
      bus.imm       = $urandom;
      bus.use_imm   = $urandom_range(0, 1) != 0;
      bus.ctrl_in   = 3'($urandom_range(0, 7));
      bus.flush     = $urandom_range(0, 15) == 0;
      bus.wr_en     = $urandom_range(0, 1) != 0;
      bus.wr_addr   = 5'($urandom_range(0, 11));
      bus.wr_data   = $urandom;
      bus.out_ready = $urandom_range(0, 3) != 0;
      #1;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_pre cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rand_post cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_read();
    test_x0_imm();
    test_backpressure();
    test_flush();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
